// File: rtl/add_share_sched_pkg.sv
// Shared types and helpers for the add_share_sched adder-sharing scheduler.
package add_share_sched_pkg;

    // S_ARB: round-robin arbitration; S_LOCK: grant held by one multi-beat packet
    typedef enum logic {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } sched_state_t;

    // Width of a requester index: max(1, clog2(n))
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_share_rr_pick.sv
// Round-robin picker: first valid index scanning ptr, ptr+1, ... (mod NUM_REQ).
module add_share_rr_pick
    import add_share_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan from the farthest offset down so the closest valid to ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int j;
            j = int'(ptr) + off;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (valid[ID_W'(j)]) begin
                idx = ID_W'(j);
                any = 1'b1;
            end
        end
        grant[idx] = any;
    end

endmodule

// File: rtl/sqrt_carry_select_adder.sv
// Carry-select adder built from sqrt(WIDTH)-sized blocks. Each block precomputes
// its sum for carry-in 0 and 1; the incoming block carry only drives a select.
module SqrtCarrySelectAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Smallest block size whose square covers WIDTH
    function automatic int isqrt_ceil(input int n);
        int r;
        r = 1;
        while (r * r < n) r++;
        return r;
    endfunction

    localparam int BLK  = isqrt_ceil(WIDTH);
    localparam int NBLK = (WIDTH + BLK - 1) / BLK;

    logic [NBLK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int LO = i * BLK;
        localparam int BW = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

        logic [BW:0] s0;
        logic [BW:0] s1;

        assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
        assign s1 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]} + (BW+1)'(1);

        assign sum[LO +: BW] = c[i] ? s1[BW-1:0] : s0[BW-1:0];
        assign c[i+1]        = c[i] ? s1[BW]     : s0[BW];
    end

    assign cout = c[NBLK];

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one carry-select adder among NUM_REQ requesters.
// Multi-beat packets lock the grant and chain carry between beats.
// Pipeline: S1 operand register -> adder -> S2 result register (rsp_*).
// Optional build macro ADD_SHARE_SCHED_PERF_EN adds the perf_beats counter port.
module add_share_sched
    import add_share_sched_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_last
`ifdef ADD_SHARE_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_beats
`endif
);

    // Pointer to the requester after g, wrapping at NUM_REQ
    function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    sched_state_t state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] g_idx;
    logic            fire;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    logic             s2_load, s1_adv, accept_ok;

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1, b_p1;
    logic             cin_p1, first_p1, last_p1;
    logic [ID_W-1:0]  id_p1;
    logic             chain_c;

    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             vld_p2;
    logic [WIDTH-1:0] sum_p2;
    logic             cout_p2, last_p2;
    logic [ID_W-1:0]  id_p2;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    add_share_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign s2_load   = !vld_p2 || rsp_ready;
    assign s1_adv    = vld_p1 && s2_load;
    assign accept_ok = !vld_p1 || s1_adv;

    // Grant selection and next state; nothing is granted while rst is high
    always_comb begin
        req_ready = '0;
        state_nxt = state;
        fire      = 1'b0;
        g_idx     = pick_idx;
        case (state)
            S_ARB: begin
                if (accept_ok && pick_any && !rst) begin
                    req_ready = pick_grant;
                    fire      = 1'b1;
                    if (!req_last[pick_idx]) state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                g_idx = lock_id;
                if (accept_ok && req_valid[lock_id] && !rst) begin
                    req_ready[lock_id] = 1'b1;
                    fire               = 1'b1;
                    if (req_last[lock_id]) state_nxt = S_ARB;
                end
            end
            default: state_nxt = S_ARB;
        endcase
    end

    // Scheduler state, round-robin pointer and packet lock
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_ARB;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (fire && req_last[g_idx]) rr_ptr <= ptr_after(g_idx);
            if (fire && state == S_ARB)  lock_id <= g_idx;
        end
    end

    // ---- stage 1: granted operands ----
    // S1 valid and the beat-to-beat carry chain
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            chain_c <= 1'b0;
        end else begin
            if (fire)        vld_p1 <= 1'b1;
            else if (s1_adv) vld_p1 <= 1'b0;
            if (s1_adv)      chain_c <= add_cout;
        end
    end

    // S1 operand capture on each accepted beat
    always_ff @(posedge clk) begin
        if (fire) begin
            a_p1     <= a_arr[g_idx];
            b_p1     <= b_arr[g_idx];
            cin_p1   <= req_cin[g_idx];
            last_p1  <= req_last[g_idx];
            id_p1    <= g_idx;
            first_p1 <= (state == S_ARB);
        end
    end

    assign add_cin = first_p1 ? cin_p1 : chain_c;

    SqrtCarrySelectAdder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (a_p1),
        .b    (b_p1),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---- stage 2: result register ----
    // Result register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            id_p2   <= '0;
            last_p2 <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sum_p2  <= add_sum;
                cout_p2 <= add_cout;
                id_p2   <= id_p1;
                last_p2 <= last_p1;
            end
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_sum   = sum_p2;
    assign rsp_cout  = cout_p2;
    assign rsp_id    = id_p2;
    assign rsp_last  = last_p2;

`ifdef ADD_SHARE_SCHED_PERF_EN
    // Count accepted request beats, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst)       perf_beats <= '0;
        else if (fire) perf_beats <= perf_beats + 32'd1;
    end
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// Directed bench for add_share_sched (default build, 4 requesters x 32 bits).
module tb_add_share_sched;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_cin, req_last;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_cout, rsp_last;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_id;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed table: {cout,sum} = a + b + cin
    logic [W-1:0] ta [N] = '{32'h0000_0005, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [W-1:0] tb [N] = '{32'h0000_0003, 32'h1111_1111, 32'h8000_0000, 32'h0000_0020};
    logic         tc [N] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] es [N] = '{32'h0000_0008, 32'h2345_678A, 32'h0000_0000, 32'h0000_0011};
    logic         ec [N] = '{1'b0, 1'b0, 1'b1, 1'b1};

    add_share_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic l);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_last[i]     = l;
    endtask

    task automatic chk_rsp(input string tag, input int id, input logic [W-1:0] s,
                           input logic c, input logic l);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_sum"},   64'(rsp_sum),   64'(s));
        chk({tag, "_cout"},  64'(rsp_cout),  64'(c));
        chk({tag, "_id"},    64'(rsp_id),    64'(id));
        chk({tag, "_last"},  64'(rsp_last),  64'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_rdy;
        int           accepted;

        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_last  = '1;
        rsp_ready = 1'b1;

        // Reset with every requester asking
        tick();
        chk("rst_ready0", 64'(req_ready), 64'd0);
        chk("rst_valid0", 64'(rsp_valid), 64'd0);
        tick();
        chk("rst_ready1", 64'(req_ready), 64'd0);
        chk("rst_valid1", 64'(rsp_valid), 64'd0);
        chk("rst_sum",    64'(rsp_sum),   64'd0);
        chk("rst_cout",   64'(rsp_cout),  64'd0);
        chk("rst_id",     64'(rsp_id),    64'd0);
        chk("rst_last",   64'(rsp_last),  64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'b0001);
        req_valid = '0;
        tick();

        // Single beat from requester 1: FFFF_FFFF + 1 -> 0 carry 1
        set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        req_valid = 4'b0010;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk("single_lat1", 64'(rsp_valid), 64'd0);
        tick();
        chk_rsp("single", 1, 32'h0, 1'b1, 1'b1);
        tick();
        chk("single_drain", 64'(rsp_valid), 64'd0);

        // Round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i], tc[i], 1'b1);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            chk("rr_ready", 64'(req_ready), 64'(exp_rdy));
            if (k >= 2) chk_rsp("rr_rsp", (k - 2) % 4, es[(k-2)%4], ec[(k-2)%4], 1'b1);
            else        chk("rr_empty", 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("rr_done", 64'(rsp_valid), 64'd0);

        // Chained 64-bit add on requester 2 with 0 and 3 competing
        set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk("chain_b1_ready", 64'(req_ready), 64'b0100);
        tick();
        for (int j = 0; j < 3; j++) begin
            req_valid = 4'b1001;
            #1;
            chk("chain_lock_ready", 64'(req_ready), 64'd0);
            if (j == 1) chk_rsp("chain_b1", 2, 32'h0, 1'b1, 1'b0);
            else        chk("chain_idle_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        set_op(2, 32'h0, 32'h0, 1'b0, 1'b1);
        req_valid = 4'b1101;
        #1;
        chk("chain_b2_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("chain_next_grant", 64'(req_ready), 64'b1000);
        req_valid = '0;
        tick();
        chk_rsp("chain_b2", 2, 32'h1, 1'b0, 1'b1);
        tick();
        chk("chain_drain", 64'(rsp_valid), 64'd0);

        // Backpressure: pointer now at 3
        for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i], tc[i], 1'b1);
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'b1111;
            #1;
            exp_rdy = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : 4'b0000;
            chk("bp_ready", 64'(req_ready), 64'(exp_rdy));
            if (req_ready != '0) accepted++;
            if (k >= 2) chk_rsp("bp_hold", 3, es[3], ec[3], 1'b1);
            else        chk("bp_empty", 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("bp_accepted", 64'(accepted), 64'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk_rsp("bp_rel3", 3, es[3], ec[3], 1'b1);
        tick();
        chk_rsp("bp_rel0", 0, es[0], ec[0], 1'b1);
        tick();
        chk("bp_drain", 64'(rsp_valid), 64'd0);

        // Reset in the middle of a packet from requester 1 (pointer at 1)
        set_op(1, 32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0);
        req_valid = 4'b0010;
        #1;
        chk("mid_b1_ready", 64'(req_ready), 64'b0010);
        tick();
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_post_grant", 64'(req_ready), 64'b0001);
        req_valid = '0;
        tick();
        chk("mid_no_ghost0", 64'(rsp_valid), 64'd0);
        tick();
        chk("mid_no_ghost1", 64'(rsp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
